// File: rtl/parc_core_rob_pkg.sv
// Shared ROB constants and writeback requester indices for the PARC core.
package parc_core_rob_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned ROB_SLOT_W = 4;
  localparam int unsigned PREG_W     = 5;
  localparam int unsigned DATA_W     = 32;

  localparam int unsigned WB_MULDIV = 0;
  localparam int unsigned WB_ALU    = 1;
  localparam int unsigned WB_MEM    = 2;

endpackage

// File: rtl/parc_core_rr_arb.sv
// Combinational round-robin arbiter: scans req upward from ptr, wrapping at N.
// Returns a one-hot grant and its index. Shared with the issue scheduler.
module parc_core_rr_arb #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = {{(32 - IDX_W){1'b0}}, ptr} + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx[IDX_W-1:0];
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parc_core_rob_fill_arb.sv
// Arbitrates NREQ writeback sources onto the single registered ROB fill port.
// Define PARC_ROB_FILL_FIXED_PRIO_EN for lowest-index-wins fixed priority.
module parc_core_rob_fill_arb #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned SLOT_W = parc_core_rob_pkg::ROB_SLOT_W,
  parameter int unsigned DATA_W = parc_core_rob_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NREQ-1:0]          fill_req_val,
  output logic [NREQ-1:0]          fill_req_rdy,
  input  logic [NREQ*SLOT_W-1:0]   fill_req_slot,
  input  logic [NREQ*DATA_W-1:0]   fill_req_data,
  output logic                     rob_fill_val,
  output logic [SLOT_W-1:0]        rob_fill_slot,
  output logic [DATA_W-1:0]        rob_fill_data
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]   buf_val_q;
  logic [SLOT_W-1:0] buf_slot_q [NREQ];
  logic [DATA_W-1:0] buf_data_q [NREQ];

  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  accept;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] arb_ptr;
  logic             any_grant;

`ifdef PARC_ROB_FILL_FIXED_PRIO_EN
  // Scanning from index 0 every cycle gives lowest-index-wins priority.
  assign arb_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q;

  assign arb_ptr = rr_ptr_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rr_ptr_q <= '0;
    end else if (any_grant) begin
      rr_ptr_q <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  parc_core_rr_arb #(
    .N     (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (buf_val_q),
    .ptr       (arb_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign any_grant = |grant;

  // A buffer being drained this cycle can take a new request at the same time.
  always_comb begin
    fill_req_rdy = '0;
    if (!reset) fill_req_rdy = flush ? '1 : (~buf_val_q | grant);
    accept = fill_req_val & fill_req_rdy;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      buf_val_q <= '0;
    end else begin
      buf_val_q <= (buf_val_q & ~grant) | accept;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NREQ); i++) begin
      if (accept[i]) begin
        buf_slot_q[i] <= fill_req_slot[i*SLOT_W +: SLOT_W];
        buf_data_q[i] <= fill_req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rob_fill_val  <= 1'b0;
      rob_fill_slot <= '0;
      rob_fill_data <= '0;
    end else begin
      rob_fill_val <= any_grant && !flush;
      if (any_grant) begin
        rob_fill_slot <= buf_slot_q[grant_idx];
        rob_fill_data <= buf_data_q[grant_idx];
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        for (int j = i + 1; j < int'(NREQ); j++) begin
          if (buf_val_q[i] && buf_val_q[j] && buf_slot_q[i] == buf_slot_q[j]) begin
            $error("rob_fill_arb: sources %0d and %0d hold the same slot %0d", i, j,
                   buf_slot_q[i]);
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_parc_core_rob_fill_arb.sv
// Scoreboard bench for parc_core_rob_fill_arb; fixed-priority case runs when
// PARC_ROB_FILL_FIXED_PRIO_EN is defined.
module tb_parc_core_rob_fill_arb;

  localparam int NREQ = 3;
  localparam int SW   = 4;
  localparam int DW   = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 flush = 1'b0;
  logic [NREQ-1:0]      fill_req_val = '0;
  logic [NREQ-1:0]      fill_req_rdy;
  logic [NREQ*SW-1:0]   fill_req_slot = '0;
  logic [NREQ*DW-1:0]   fill_req_data = '0;
  logic                 rob_fill_val;
  logic [SW-1:0]        rob_fill_slot;
  logic [DW-1:0]        rob_fill_data;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  parc_core_rob_fill_arb #(
    .NREQ   (NREQ),
    .SLOT_W (SW),
    .DATA_W (DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .fill_req_val  (fill_req_val),
    .fill_req_rdy  (fill_req_rdy),
    .fill_req_slot (fill_req_slot),
    .fill_req_data (fill_req_data),
    .rob_fill_val  (rob_fill_val),
    .rob_fill_slot (rob_fill_slot),
    .rob_fill_data (rob_fill_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int s, input logic [SW-1:0] slot, input logic [DW-1:0] data);
    fill_req_val[s]            = 1'b1;
    fill_req_slot[s*SW +: SW]  = slot;
    fill_req_data[s*DW +: DW]  = data;
  endtask

  task automatic push_fill(input logic [SW-1:0] slot, input logic [DW-1:0] data);
    sb.push_back({28'b0, slot, data});
  endtask

  // Every fill strobe must match the oldest expected fill.
  always @(negedge clk) begin
    if (rob_fill_val === 1'b1) begin
      if (sb.size() == 0) check("fill_unexpected", 64'(rob_fill_val), 64'd0);
      else check("fill", {28'b0, rob_fill_slot, rob_fill_data}, sb.pop_front());
    end
  end

  initial begin
    // Reset values and rdy behaviour around reset.
    step();
    @(negedge clk);
    check("rst_rdy", 64'(fill_req_rdy), 64'd0);
    check("rst_val", 64'(rob_fill_val), 64'd0);
    check("rst_slot", 64'(rob_fill_slot), 64'd0);
    check("rst_data", 64'(rob_fill_data), 64'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 64'(fill_req_rdy), 64'h7);

    // Single request: strobe two cycles after acceptance, for one cycle only.
    step();
    set_req(1, 4'd5, 32'hA5);
    push_fill(4'd5, 32'hA5);
    @(negedge clk);
    check("t1_val_c0", 64'(rob_fill_val), 64'd0);
    step();
    fill_req_val = '0;
    @(negedge clk);
    check("t1_val_c1", 64'(rob_fill_val), 64'd0);
    step();
    @(negedge clk);
    check("t1_val_c2", 64'(rob_fill_val), 64'd1);
    step();
    @(negedge clk);
    check("t1_val_c3", 64'(rob_fill_val), 64'd0);

`ifndef PARC_ROB_FILL_FIXED_PRIO_EN
    // Full contention: grants rotate 0,1,2 and each source reloads when granted.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c <= 13; c++) begin
      if (c <= 9) begin
        for (int s = 0; s < NREQ; s++) set_req(s, SW'(s + 1), DW'((s << 8) | c));
      end else begin
        fill_req_val = '0;
      end
      if (c >= 1 && c <= 12) begin
        int s;
        int ld;
        s  = (c - 1) % 3;
        ld = (c >= 4) ? c - 3 : 0;
        push_fill(SW'(s + 1), DW'((s << 8) | ld));
      end
      @(negedge clk);
      if (c == 0) check("t2_rdy_c0", 64'(fill_req_rdy), 64'h7);
      else if (c <= 9) check("t2_rdy_onehot", 64'(fill_req_rdy), 64'(1 << ((c - 1) % 3)));
      if (c >= 2) check("t2_val_cont", 64'(rob_fill_val), 64'd1);
      step();
    end
`endif

    // Flush squashes buffered fills and a request arriving in the flush cycle.
    for (int k = 0; k < 3; k++) step();
    set_req(0, 4'd7, 32'h77);
    set_req(2, 4'd9, 32'h99);
    @(negedge clk);
    check("t3_val_pre", 64'(rob_fill_val), 64'd0);
    step();
    fill_req_val = '0;
    flush = 1'b1;
    set_req(1, 4'd11, 32'hBB);
    @(negedge clk);
    check("t3_rdy_flush", 64'(fill_req_rdy), 64'h7);
    step();
    flush = 1'b0;
    fill_req_val = '0;
    @(negedge clk);
    check("t3_val_post", 64'(rob_fill_val), 64'd0);
    check("t3_bufs_clear", 64'(fill_req_rdy), 64'h7);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      check("t3_val_quiet", 64'(rob_fill_val), 64'd0);
    end

`ifndef PARC_ROB_FILL_FIXED_PRIO_EN
    // Drive rr_ptr to 2, then buffers 0 and 2 compete: 2 wins, then 0, ptr ends at 1.
    step();
    set_req(1, 4'd1, 32'h11);
    push_fill(4'd1, 32'h11);
    step();
    fill_req_val = '0;
    step();
    step();
    set_req(0, 4'd12, 32'hC0);
    set_req(2, 4'd13, 32'hD0);
    push_fill(4'd13, 32'hD0);
    push_fill(4'd12, 32'hC0);
    step();
    fill_req_val = '0;
    @(negedge clk);
    check("t4_rdy_g2", 64'(fill_req_rdy), 64'h6);
    step();
    @(negedge clk);
    check("t4_rdy_g0", 64'(fill_req_rdy), 64'h7);
    step();
    set_req(0, 4'd2, 32'h20);
    set_req(1, 4'd3, 32'h30);
    push_fill(4'd3, 32'h30);
    push_fill(4'd2, 32'h20);
    step();
    fill_req_val = '0;
    for (int k = 0; k < 3; k++) step();
`endif

    // Reset while three fills are buffered: nothing reaches the fill port.
    for (int k = 0; k < 3; k++) step();
    set_req(0, 4'd4, 32'h40);
    set_req(1, 4'd5, 32'h50);
    set_req(2, 4'd6, 32'h60);
    step();
    fill_req_val = '0;
    reset = 1'b1;
    @(negedge clk);
    check("t5_rdy_rst", 64'(fill_req_rdy), 64'd0);
    step();
    @(negedge clk);
    check("t5_val_rst", 64'(rob_fill_val), 64'd0);
    check("t5_slot_rst", 64'(rob_fill_slot), 64'd0);
    check("t5_data_rst", 64'(rob_fill_data), 64'd0);
    check("t5_rdy_rst2", 64'(fill_req_rdy), 64'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t5_rdy_after", 64'(fill_req_rdy), 64'h7);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_val_quiet", 64'(rob_fill_val), 64'd0);
      step();
    end

`ifdef PARC_ROB_FILL_FIXED_PRIO_EN
    // Fixed priority: source 0 wins every cycle while source 1 waits.
    for (int c = 0; c <= 7; c++) begin
      if (c <= 5) begin
        set_req(0, 4'd1, DW'(32'h600 | c));
        set_req(1, 4'd2, DW'(32'h700 | c));
      end else begin
        fill_req_val = '0;
      end
      if (c >= 1 && c <= 6) push_fill(4'd1, DW'(32'h600 | (c - 1)));
      if (c == 7) push_fill(4'd2, 32'h700);
      @(negedge clk);
      if (c >= 1 && c <= 5) check("t6_rdy", 64'(fill_req_rdy), 64'h5);
      if (c >= 2) check("t6_val", 64'(rob_fill_val), 64'd1);
      step();
    end
`endif

    fill_req_val = '0;
    for (int k = 0; k < 20 && sb.size() > 0; k++) step();
    step();
    check("sb_drain", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
